pipe_latch_chain: RTL

PIPE_LATCH_CHAIN -- requirements
Module: pipe_latch_chain

---
 rtl/pipe_latch_chain.sv | 101 ++++++++++
 1 files changed

// File: rtl/pipe_latch_chain.sv
// Parameterised pipeline latch chain with per-stage stall and flush control
// and free-running performance counters.
module pipe_latch_chain #(
    parameter int STAGES   = 5,
    parameter int WIDTH    = 32,
    parameter int CNT_BITS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    in_data,
    output logic                in_ready,
    input  logic [STAGES-1:0]   stall_req,
    input  logic [STAGES-1:0]   flush_req,
    output logic                out_valid,
    output logic [WIDTH-1:0]    out_data,
    input  logic                cnt_clr,
    output logic [CNT_BITS-1:0] cycle_count,
    output logic [CNT_BITS-1:0] retired_count,
    output logic [CNT_BITS-1:0] bubble_count
);

    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    logic [STAGES-1:0] r_v;
    logic [WIDTH-1:0]  r_d [STAGES];
    logic [STAGES-1:0] w_v_nxt;
    logic [WIDTH-1:0]  w_d_nxt [STAGES];

    logic w_stall_any;
    logic w_flush_any;
    int   w_stall_idx;
    int   w_flush_idx;
    logic w_retire;

    // Highest requesting stage wins for both stall and flush.
    always_comb begin
        w_stall_any = |stall_req;
        w_flush_any = |flush_req;
        w_stall_idx = 0;
        w_flush_idx = 0;
        for (int k = 0; k < STAGES; k++) begin
            if (stall_req[k]) w_stall_idx = k;
            if (flush_req[k]) w_flush_idx = k;
        end
    end

    assign in_ready = !w_stall_any && !w_flush_any;
    assign w_retire = r_v[STAGES-1] && !stall_req[STAGES-1];

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_v_nxt = r_v;
        w_d_nxt = r_d;
        for (int j = 1; j < STAGES; j++) begin
            if (!w_stall_any || j > w_stall_idx + 1) begin
                w_v_nxt[j] = r_v[j-1];
                w_d_nxt[j] = r_d[j-1];
            end else if (j == w_stall_idx + 1) begin
                w_v_nxt[j] = 1'b0;
            end
        end
        if (in_ready) begin
            w_v_nxt[0] = in_valid;
            if (in_valid) w_d_nxt[0] = in_data;
        end
        // Flush kills the entries that end up at or below the flushing stage.
        if (w_flush_any) begin
            for (int j = 0; j < STAGES; j++) begin
                if (j <= w_flush_idx) w_v_nxt[j] = 1'b0;
            end
        end
    end

    // NOTE: payload registers are reset too, because out_data must read 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v <= '0;
            for (int k = 0; k < STAGES; k++) r_d[k] <= '0;
        end else begin
            r_v <= w_v_nxt;
            r_d <= w_d_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            cycle_count   <= '0;
            retired_count <= '0;
            bubble_count  <= '0;
        end else begin
            cycle_count <= cycle_count + CNT_ONE;
            if (w_retire)      retired_count <= retired_count + CNT_ONE;
            if (!r_v[STAGES-1]) bubble_count <= bubble_count + CNT_ONE;
        end
    end

    assign out_valid = r_v[STAGES-1];
    assign out_data  = r_d[STAGES-1];

endmodule
